// File: rtl/ysyx_23060221_axi_sram_slave.sv
// rtl/ysyx_23060221_axi_sram_slave.sv - AXI4 responder over a word-addressed SRAM, one transaction at a time.
// Optional random stall injection: YSYX_23060221_AXI_SRAM_DELAY_EN.
module ysyx_23060221_axi_sram_slave #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam logic [31:0] SPAN = 32'(4) << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RDATA, WDATA, BRESP} state_t;

    state_t      state_q;
    logic        prio_rd_q, rdy_en_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q, cnt_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [3:0]  id_q;
    logic        dec_q, slv_q;
    logic        rvalid_q, rlast_q, bvalid_q;
    logic [1:0]  rresp_q, bresp_q;
    logic [31:0] rdata_q;
    logic [3:0]  rid_q, bid_q;
    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic        go;

`ifdef YSYX_23060221_AXI_SRAM_DELAY_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign go = lfsr_q[0];
`else
    assign go = 1'b1;
`endif

    function automatic logic in_range(input logic [31:0] a);
        return (a - BASE) < SPAN;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[DEPTH_LOG2+1:2];
    endfunction

    logic        idle_go, ar_hs, aw_hs, w_hs, w_last_beat, w_done, w_dec, w_slv;
    logic [31:0] nxt_addr;

    assign idle_go     = (state_q == IDLE) && rdy_en_q && go;
    assign arready     = idle_go && (!awvalid || prio_rd_q);
    assign awready     = idle_go && (!arvalid || !prio_rd_q);
    assign wready      = (state_q == WDATA) && go;
    assign ar_hs       = arvalid && arready;
    assign aw_hs       = awvalid && awready && !ar_hs;
    assign w_hs        = wvalid && wready;
    assign w_last_beat = (cnt_q == len_q);
    assign w_done      = w_last_beat || wlast;
    assign w_dec       = dec_q || !in_range(addr_q);
    assign w_slv       = slv_q || (wlast != w_last_beat);
    assign nxt_addr    = (burst_q == 2'b00) ? addr_q : addr_q + (32'(1) << size_q);

    // Selects which address, if any, gets loaded into the read-data registers this cycle.
    logic        rd_load, rd_last;
    logic [31:0] rd_a;
    always_comb begin
        rd_load = 1'b0;
        rd_a    = addr_q;
        rd_last = (cnt_q == len_q);
        if (ar_hs) begin
            rd_load = go;
            rd_a    = araddr;
            rd_last = (arlen == 8'd0);
        end else if (state_q == RDATA) begin
            if (rvalid_q && rready && !rlast_q) begin
                rd_load = go;
                rd_a    = nxt_addr;
                rd_last = ((cnt_q + 8'd1) == len_q);
            end else if (!rvalid_q) begin
                rd_load = go;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_hs && in_range(addr_q)) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[widx(addr_q)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            prio_rd_q <= 1'b1;
            rdy_en_q  <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            dec_q     <= 1'b0;
            slv_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            rid_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (rd_load) begin
                rvalid_q <= 1'b1;
                rdata_q  <= in_range(rd_a) ? mem[widx(rd_a)] : 32'h0;
                rresp_q  <= in_range(rd_a) ? 2'b00 : 2'b11;
                rlast_q  <= rd_last;
            end
            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        state_q   <= RDATA;
                        prio_rd_q <= !prio_rd_q;
                        addr_q    <= araddr;
                        len_q     <= arlen;
                        size_q    <= arsize;
                        burst_q   <= arburst;
                        cnt_q     <= '0;
                        rid_q     <= arid;
                    end else if (aw_hs) begin
                        state_q   <= WDATA;
                        prio_rd_q <= !prio_rd_q;
                        addr_q    <= awaddr;
                        len_q     <= awlen;
                        size_q    <= awsize;
                        burst_q   <= awburst;
                        cnt_q     <= '0;
                        id_q      <= awid;
                        dec_q     <= 1'b0;
                        slv_q     <= 1'b0;
                    end
                end
                RDATA: begin
                    if (rvalid_q && rready) begin
                        if (rlast_q) begin
                            state_q  <= IDLE;
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                        end else begin
                            addr_q <= nxt_addr;
                            cnt_q  <= cnt_q + 8'd1;
                            if (!go) rvalid_q <= 1'b0;
                        end
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        dec_q <= w_dec;
                        slv_q <= w_slv;
                        if (w_done) begin
                            state_q  <= BRESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= w_dec ? 2'b11 : (w_slv ? 2'b10 : 2'b00);
                            bid_q    <= id_q;
                        end else begin
                            addr_q <= nxt_addr;
                            cnt_q  <= cnt_q + 8'd1;
                        end
                    end
                end
                BRESP: begin
                    if (bready) begin
                        state_q  <= IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;
    assign rid    = rid_q;
    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign bid    = bid_q;
endmodule

// File: tb/tb_ysyx_23060221_axi_sram_slave.sv
// tb/tb_ysyx_23060221_axi_sram_slave.sv - self-checking bench for the AXI4 SRAM responder.
module tb_ysyx_23060221_axi_sram_slave;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SPAN = 32'h0004_0000;
    localparam int          LIM  = 200;

    logic        clock = 1'b0, reset = 1'b1;
    logic        awready, awvalid = 0, wready, wvalid = 0, wlast = 0, bready = 0, bvalid;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
    logic [3:0]  awid = 0, wstrb = 0, bid, arid = 0, rid;
    logic [7:0]  awlen = 0, arlen = 0;
    logic [2:0]  awsize = 3'd2, arsize = 3'd2;
    logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;
    logic        arready, arvalid = 0, rready = 0, rvalid, rlast;

    ysyx_23060221_axi_sram_slave dut (
        .clock(clock), .reset(reset),
        .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
    );

    always #5 clock = ~clock;

    int passed = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference memory: word index -> contents, updated from write bursts.
    logic [31:0] model [int unsigned];
    logic [31:0] wq_data[$];
    logic [3:0]  wq_strb[$];
    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic        rq_last[$];
    logic [3:0]  rq_id[$];
    int          rd_cycles, rd_lat, b_lat;
    logic [1:0]  b_resp, exp_bresp;
    logic [3:0]  b_id;

    function automatic logic in_rng(input logic [31:0] a);
        return (a - BASE) < SPAN;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == 2'b00) ? a : a + 32'(i) * 32'd4;
    endfunction

    function automatic logic [31:0] outs_vec();
        return 32'({arready, awready, wready, bvalid, bresp, bid, rvalid, rresp, rlast, rid});
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input int early);
        int nb, k;
        logic dec, slv;
        nb  = (early >= 0) ? early + 1 : int'(len) + 1;
        dec = 1'b0;
        slv = (early >= 0) && (early != int'(len));
        for (int i = 0; i < nb; i++) begin
            logic [31:0] ba, w;
            ba = beat_addr(a, burst, i);
            if (in_rng(ba)) begin
                w = model.exists((ba - BASE) >> 2) ? model[(ba - BASE) >> 2] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (wq_strb[i][b]) w[8*b +: 8] = wq_data[i][8*b +: 8];
                model[(ba - BASE) >> 2] = w;
            end else dec = 1'b1;
        end
        exp_bresp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);

        @(negedge clock);
        awvalid = 1; awaddr = a; awlen = len; awburst = burst; awid = id;
        #1 k = 0;
        while (!awready && k < LIM) begin @(negedge clock); #1 k++; end
        if (k >= LIM) chk("aw_wait", 32'(k), 0);
        @(posedge clock);
        for (int i = 0; i < nb; i++) begin
            @(negedge clock);
            awvalid = 0; wvalid = 1; wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == nb - 1);
            #1 k = 0;
            while (!wready && k < LIM) begin @(negedge clock); #1 k++; end
            if (k >= LIM) chk("w_wait", 32'(k), 0);
            @(posedge clock);
        end
        @(negedge clock);
        wvalid = 0; wlast = 0; bready = 1;
        #1 b_lat = 1;
        while (!bvalid && b_lat < LIM) begin @(negedge clock); #1 b_lat++; end
        if (b_lat >= LIM) chk("b_wait", 32'(b_lat), 0);
        b_resp = bresp; b_id = bid;
        @(posedge clock);
        @(negedge clock);
        bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input bit rand_rr);
        int k, cyc;
        bit done;
        rq_data = {}; rq_resp = {}; rq_last = {}; rq_id = {};
        @(negedge clock);
        arvalid = 1; araddr = a; arlen = len; arburst = burst; arid = id;
        #1 k = 0;
        while (!arready && k < LIM) begin @(negedge clock); #1 k++; end
        if (k >= LIM) chk("ar_wait", 32'(k), 0);
        @(posedge clock);
        @(negedge clock);
        arvalid = 0; rready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
        #1 cyc = 1; done = 0; rd_lat = 0;
        while (!done && cyc < 2000 && rq_data.size() < 300) begin
            if (rvalid && rready) begin
                if (rq_data.size() == 0) rd_lat = cyc;
                rq_data.push_back(rdata); rq_resp.push_back(rresp);
                rq_last.push_back(rlast); rq_id.push_back(rid);
                if (rlast) begin done = 1; rd_cycles = cyc; end
            end
            @(posedge clock);
            @(negedge clock);
            if (!done) begin
                rready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
                #1 cyc++;
            end
        end
        if (!done) chk("r_wait", 32'(cyc), 0);
        rready = 0;
    endtask

    task automatic check_read(input string tag, input logic [31:0] a, input logic [7:0] len,
                              input logic [1:0] burst, input logic [3:0] id);
        chk({tag, "_beats"}, 32'(rq_data.size()), 32'(len) + 1);
        for (int i = 0; i < rq_data.size() && i <= int'(len); i++) begin
            logic [31:0] ba;
            ba = beat_addr(a, burst, i);
            chk({tag, "_data"}, rq_data[i], in_rng(ba) ? model[(ba - BASE) >> 2] : 32'h0);
            chk({tag, "_resp"}, 32'(rq_resp[i]), in_rng(ba) ? 32'd0 : 32'd3);
            chk({tag, "_last"}, 32'(rq_last[i]), 32'(i == int'(len)));
            chk({tag, "_id"}, 32'(rq_id[i]), 32'(id));
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1 chk("reset_outs", outs_vec(), 0);
        chk("reset_rdata", rdata, 0);
        reset = 0;
        repeat (2) @(negedge clock);

        // Simultaneous requests after reset: read first, then write gets the turn.
        arvalid = 1; araddr = BASE + 32'h200; arlen = 0; arburst = 1; arid = 4'h3;
        awvalid = 1; awaddr = BASE + 32'h200; awlen = 0; awburst = 1; awid = 4'h4;
        #1 chk("arb_rd_first", {arready, awready}, 2'b10);
        @(posedge clock);
        @(negedge clock);
        rready = 1;
        #1 chk("arb_rvalid", rvalid, 1);
        @(posedge clock);
        @(negedge clock);
        rready = 0;
        #1 chk("arb_wr_next", {arready, awready}, 2'b01);
        arvalid = 0; awvalid = 0;

        wq_data = {32'hDEADBEEF}; wq_strb = {4'hF};
        do_write(32'h8000_0010, 0, 1, 4'h5, -1);
        chk("single_bresp", b_resp, 0);
        chk("single_bid", b_id, 4'h5);
        chk("single_blat", b_lat, 1);
        do_read(32'h8000_0010, 0, 1, 4'h9, 0);
        chk("single_lat", rd_lat, 1);
        chk("single_rdata", rq_data.size() > 0 ? rq_data[0] : 32'h0, 32'hDEADBEEF);
        check_read("single", 32'h8000_0010, 0, 1, 4'h9);
        #1 chk("ready_after_r", arready, 1);

        wq_data = {32'h11223344}; wq_strb = {4'hF};
        do_write(32'h8000_0020, 0, 1, 4'h1, -1);
        wq_data = {32'hAABBCCDD}; wq_strb = {4'b0101};
        do_write(32'h8000_0020, 0, 1, 4'h2, -1);
        do_read(32'h8000_0020, 0, 1, 4'h2, 0);
        chk("strb_merge", rq_data.size() > 0 ? rq_data[0] : 32'h0, 32'h11BB33DD);

        wq_data = {32'hA0, 32'hA1, 32'hA2, 32'hA3}; wq_strb = {4'hF, 4'hF, 4'hF, 4'hF};
        do_write(BASE + 32'h100, 3, 1, 4'h6, -1);
        chk("incr_bresp", b_resp, 0);
        do_read(BASE + 32'h100, 3, 1, 4'h7, 0);
        check_read("incr", BASE + 32'h100, 3, 1, 4'h7);
        chk("incr_cycles", rd_cycles, 4);
        do_read(BASE + 32'h104, 3, 0, 4'h8, 0);
        check_read("fixed", BASE + 32'h104, 3, 0, 4'h8);
        chk("fixed_word", rq_data.size() > 3 ? rq_data[3] : 32'h0, 32'hA1);

        do_read(BASE + SPAN, 0, 1, 4'hA, 0);
        chk("oor_rdata", rq_data.size() > 0 ? rq_data[0] : 32'h1, 0);
        chk("oor_rresp", rq_data.size() > 0 ? 32'(rq_resp[0]) : 32'h0, 3);
        wq_data = {32'h00C0FFEE}; wq_strb = {4'hF};
        do_write(BASE, 0, 1, 4'h0, -1);
        wq_data = {32'hBAD0BAD0}; wq_strb = {4'hF};
        do_write(BASE + SPAN, 0, 1, 4'hB, -1);
        chk("oor_bresp", b_resp, 3);
        do_read(BASE, 0, 1, 4'h0, 0);
        chk("oor_nochange", rq_data.size() > 0 ? rq_data[0] : 32'h0, 32'h00C0FFEE);

        wq_data = {32'hE0, 32'hE1}; wq_strb = {4'hF, 4'hF};
        do_write(BASE + 32'h300, 3, 1, 4'hC, 1);
        chk("early_bresp", b_resp, 2);
        chk("early_exp", b_resp, exp_bresp);
        do_read(BASE + 32'h300, 1, 1, 4'hC, 0);
        check_read("early_rd", BASE + 32'h300, 1, 1, 4'hC);

        // Reset during beat 2 of a read burst, then a fresh burst.
        @(negedge clock);
        arvalid = 1; araddr = BASE + 32'h100; arlen = 3; arburst = 1; arid = 4'hD;
        @(posedge clock);
        @(negedge clock);
        arvalid = 0; rready = 1;
        @(posedge clock);
        @(negedge clock);
        #1 chk("pre_rst_beat2", rdata, 32'hA1);
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        #1 chk("rst_mid_outs", outs_vec(), 0);
        chk("rst_mid_rdata", rdata, 0);
        reset = 0; rready = 0;
        repeat (2) @(negedge clock);
        do_read(BASE + 32'h100, 3, 1, 4'hE, 0);
        check_read("post_rst", BASE + 32'h100, 3, 1, 4'hE);

        for (int it = 0; it < 15; it++) begin
            logic [31:0] a;
            logic [7:0]  len;
            logic [1:0]  bu;
            a   = (it % 4 == 3) ? BASE + SPAN - 32'd4 * $urandom_range(1, 4)
                                : BASE + 32'h1000 + 32'd4 * $urandom_range(0, 60);
            len = 8'($urandom_range(0, 7));
            bu  = 2'($urandom_range(0, 3));
            wq_data = {}; wq_strb = {};
            for (int i = 0; i <= int'(len); i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
            do_write(a, len, bu, 4'($urandom), -1);
            chk("rnd_bresp1", b_resp, exp_bresp);
            wq_data = {}; wq_strb = {};
            for (int i = 0; i <= int'(len); i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'($urandom)); end
            do_write(a, len, bu, 4'h1, -1);
            chk("rnd_bresp2", b_resp, exp_bresp);
            do_read(a, len, bu, 4'(it), 1);
            check_read("rnd", a, len, bu, 4'(it));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
